// File: rtl/calc_sequencer_if.sv
// ALU handshake and register-file bus between the calculator sequencer
// (master) and the ALU / register-file blocks (slave).
interface calc_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             alu_req_o;
  logic             alu_ack_i;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [1:0]       alu_op_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_err_i;
  logic             we_o;
  logic [AW-1:0]    waddr_o;
  logic [WIDTH-1:0] wdata_o;
  logic [AW-1:0]    raddr_o;
  logic [WIDTH-1:0] rdata_i;

  modport master (
    output alu_req_o, alu_a_o, alu_b_o, alu_op_o, we_o, waddr_o, wdata_o, raddr_o,
    input  alu_ack_i, alu_result_i, alu_err_i, rdata_i
  );

  modport slave (
    input  alu_req_o, alu_a_o, alu_b_o, alu_op_o, we_o, waddr_o, wdata_o, raddr_o,
    output alu_ack_i, alu_result_i, alu_err_i, rdata_i
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds decimal operands from key events, runs one
// ALU operation per entry, logs results in a circular register file and sweeps them.
module calc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int DEPTH       = 8,
  parameter int SWEEP_COUNT = 10_000_000,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             key_valid_i,
  input  logic [3:0]       key_code_i,
  input  logic             mode_i,
  calc_sequencer_if.master bus,
  output logic [WIDTH-1:0] display_o,
  output logic             error_o,
  output logic [2:0]       state_o,
  output logic [AW:0]      count_o
);

  localparam int DW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(SWEEP_COUNT + 1);

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    WAIT_ALU = 3'd2,
    WRITE    = 3'd3,
    SWEEP    = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] acc, input logic [3:0] d);
    return (acc * WIDTH'(4'd10)) + WIDTH'(d);
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_acc_a, r_acc_b, r_wdata, r_display;
  logic [DW-1:0]    r_dig_a, r_dig_b;
  logic [1:0]       r_op;
  logic [AW-1:0]    r_wptr, r_waddr, r_raddr;
  logic [AW:0]      r_count;
  logic [TW-1:0]    r_timer;
  logic             r_alu_req, r_we, r_error;

  logic             w_is_digit, w_is_op, w_is_enter, w_is_clear, w_raddr_last;
  logic [WIDTH-1:0] w_mac_a, w_mac_b;

  assign w_is_digit   = key_valid_i && (key_code_i <= 4'd9);
  assign w_is_op      = key_valid_i && (key_code_i >= 4'd10) && (key_code_i <= 4'd13);
  assign w_is_enter   = key_valid_i && (key_code_i == 4'd14);
  assign w_is_clear   = key_valid_i && (key_code_i == 4'd15);
  assign w_mac_a      = mac10(r_acc_a, key_code_i);
  assign w_mac_b      = mac10(r_acc_b, key_code_i);
  // Also true with an empty file, which pins the sweep address at 0.
  assign w_raddr_last = ({1'b0, r_raddr} + (AW+1)'(1)) >= r_count;

  // Sequencer FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= GET_A;
      r_acc_a   <= '0;
      r_acc_b   <= '0;
      r_dig_a   <= '0;
      r_dig_b   <= '0;
      r_op      <= 2'd0;
      r_wptr    <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_raddr   <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_alu_req <= 1'b0;
      r_we      <= 1'b0;
      r_error   <= 1'b0;
      r_display <= '0;
    end else begin
      r_error <= 1'b0;
      r_we    <= 1'b0;
      case (r_state)
        GET_A: begin
          if (mode_i && (r_dig_a == '0)) begin
            r_state   <= SWEEP;
            r_timer   <= '0;
            r_raddr   <= '0;
            r_display <= '0;
          end else if (w_is_digit) begin
            if (r_dig_a < DW'(DIGITS)) begin
              r_acc_a   <= w_mac_a;
              r_dig_a   <= r_dig_a + DW'(1);
              r_display <= w_mac_a;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_op) begin
            if (r_dig_a != '0) begin
              r_op      <= 2'(key_code_i - 4'd10);
              r_state   <= GET_B;
              r_display <= r_acc_b;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_enter) begin
            r_error <= 1'b1;
          end else if (w_is_clear) begin
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_dig_a   <= '0;
            r_dig_b   <= '0;
            r_display <= '0;
          end
        end
        GET_B: begin
          if (w_is_digit) begin
            if (r_dig_b < DW'(DIGITS)) begin
              r_acc_b   <= w_mac_b;
              r_dig_b   <= r_dig_b + DW'(1);
              r_display <= w_mac_b;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_op) begin
            r_error <= 1'b1;
          end else if (w_is_enter) begin
            if (r_dig_b != '0) begin
              r_state   <= WAIT_ALU;
              r_alu_req <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_clear) begin
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_dig_a   <= '0;
            r_dig_b   <= '0;
            r_display <= '0;
            r_state   <= GET_A;
          end
        end
        WAIT_ALU: begin
          // Key events are deliberately not decoded here, so an ack always wins.
          if (bus.alu_ack_i) begin
            r_alu_req <= 1'b0;
            if (bus.alu_err_i) begin
              r_error   <= 1'b1;
              r_acc_a   <= '0;
              r_acc_b   <= '0;
              r_dig_a   <= '0;
              r_dig_b   <= '0;
              r_display <= '0;
              r_state   <= GET_A;
            end else begin
              r_we      <= 1'b1;
              r_waddr   <= r_wptr;
              r_wdata   <= bus.alu_result_i;
              r_display <= bus.alu_result_i;
              r_state   <= WRITE;
            end
          end
        end
        WRITE: begin
          r_wptr  <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
          r_count <= (r_count == (AW+1)'(DEPTH)) ? r_count : r_count + (AW+1)'(1);
          r_acc_a <= '0;
          r_acc_b <= '0;
          r_dig_a <= '0;
          r_dig_b <= '0;
          r_state <= GET_A;
        end
        SWEEP: begin
          if (!mode_i) begin
            r_raddr   <= '0;
            r_timer   <= '0;
            r_display <= r_acc_a;
            r_state   <= GET_A;
          end else begin
            r_display <= (r_count == '0) ? '0 : bus.rdata_i;
            if (r_timer == TW'(SWEEP_COUNT - 1)) begin
              r_timer <= '0;
              r_raddr <= w_raddr_last ? '0 : r_raddr + AW'(1);
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        default: begin
          r_state   <= GET_A;
          r_alu_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_req_o = r_alu_req;
  assign bus.alu_a_o   = r_acc_a;
  assign bus.alu_b_o   = r_acc_b;
  assign bus.alu_op_o  = r_op;
  assign bus.we_o      = r_we;
  assign bus.waddr_o   = r_waddr;
  assign bus.wdata_o   = r_wdata;
  assign bus.raddr_o   = r_raddr;
  assign display_o     = r_display;
  assign error_o       = r_error;
  assign state_o       = r_state;
  assign count_o       = r_count;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer against a transaction-level
// model of operand entry, the circular result log and the sweep rotation.
module tb_calc_sequencer;
  localparam int WIDTH = 16;
  localparam int DIGITS = 4;
  localparam int DEPTH = 8;
  localparam int SC = 4;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] display;
  logic             error;
  logic [2:0]       state;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rf [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  int exp_mem [DEPTH];
  int exp_wptr = 0;
  int exp_nops = 0;

  calc_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus();

  calc_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS), .DEPTH(DEPTH), .SWEEP_COUNT(SC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .key_valid_i(key_valid), .key_code_i(key_code),
    .mode_i(mode), .bus(bus), .display_o(display), .error_o(error),
    .state_o(state), .count_o(count)
  );

  always #5 clk = ~clk;

  assign bus.rdata_i = rf[bus.raddr_o];
  always @(posedge clk) if (bus.we_o) rf[bus.waddr_o] <= bus.wdata_o;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_count();
    return (exp_nops > DEPTH) ? DEPTH : exp_nops;
  endfunction

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter_num(input int nd, input string tag, output int val);
    val = 0;
    for (int i = 0; i < nd; i++) begin
      int d;
      d = $urandom_range(9);
      press(4'(d));
      val = (val * 10 + d) % 65536;
      check_eq(tag, display, val);
    end
  endtask

  task automatic model_reset();
    exp_wptr = 0;
    exp_nops = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;
  endtask

  task automatic run_op(input bit err_flag, input bit inject);
    int a, b, op, res;
    enter_num($urandom_range(1, 4), "disp_a", a);
    op = $urandom_range(3);
    press(4'(10 + op));
    check_eq("state_getb", state, 1);
    if (inject) begin
      press(4'(10 + $urandom_range(3)));
      check_eq("op_in_b_err", error, 1);
      press(4'd14);
      check_eq("e_nodig_err", error, 1);
      check_eq("e_nodig_state", state, 1);
    end
    enter_num($urandom_range(1, 4), "disp_b", b);
    press(4'd14);
    check_eq("state_wait", state, 2);
    check_eq("req_up", bus.alu_req_o, 1);
    check_eq("alu_a", bus.alu_a_o, a);
    check_eq("alu_b", bus.alu_b_o, b);
    check_eq("alu_op", bus.alu_op_o, op);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    check_eq("req_held", bus.alu_req_o, 1);
    case (op)
      0: res = a + b;
      1: res = a - b;
      2: res = a * b;
      default: res = a ^ b;
    endcase
    res = res & 32'h0000_FFFF;
    bus.alu_ack_i = 1'b1;
    bus.alu_err_i = err_flag;
    bus.alu_result_i = res[15:0];
    key_valid = 1'b1;
    key_code = 4'd5;
    @(negedge clk);
    bus.alu_ack_i = 1'b0;
    bus.alu_err_i = 1'b0;
    key_valid = 1'b0;
    check_eq("req_drop", bus.alu_req_o, 0);
    if (!err_flag) begin
      check_eq("we_pulse", bus.we_o, 1);
      check_eq("waddr", bus.waddr_o, exp_wptr);
      check_eq("wdata", bus.wdata_o, res);
      check_eq("state_write", state, 3);
      exp_mem[exp_wptr] = res;
      exp_wptr = (exp_wptr + 1) % DEPTH;
      exp_nops++;
      @(negedge clk);
      check_eq("we_single", bus.we_o, 0);
      check_eq("state_back", state, 0);
      check_eq("disp_result", display, res);
      check_eq("count", count, exp_count());
      check_eq("a_cleared", bus.alu_a_o, 0);
    end else begin
      check_eq("err_no_we", bus.we_o, 0);
      check_eq("err_pulse", error, 1);
      check_eq("err_state", state, 0);
      check_eq("err_disp", display, 0);
      @(negedge clk);
      check_eq("err_single", error, 0);
      check_eq("err_count", count, exp_count());
    end
  endtask

  task automatic sweep_check(input int steps);
    int cnt, ea, ed;
    cnt = exp_count();
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    check_eq("sweep_state", state, 4);
    check_eq("sweep_raddr0", bus.raddr_o, 0);
    for (int k = 1; k <= steps; k++) begin
      key_valid = (k == 2);
      key_code = 4'd7;
      @(negedge clk);
      ea = (cnt == 0) ? 0 : (k / SC) % cnt;
      ed = (cnt == 0) ? 0 : exp_mem[((k - 1) / SC) % cnt];
      check_eq("sweep_raddr", bus.raddr_o, ea);
      check_eq("sweep_disp", display, ed);
      check_eq("sweep_hold", state, 4);
    end
    key_valid = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    check_eq("exit_state", state, 0);
    check_eq("exit_raddr", bus.raddr_o, 0);
    check_eq("exit_disp", display, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.alu_ack_i = 1'b0;
    bus.alu_err_i = 1'b0;
    bus.alu_result_i = '0;
    for (int i = 0; i < DEPTH; i++) rf[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_disp", display, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_req", bus.alu_req_o, 0);
    check_eq("rst_we", bus.we_o, 0);
    rst_n = 1'b1;

    sweep_check(6);

    // Directed: 12 A 3 E, ALU answers 15.
    press(4'd1);
    press(4'd2);
    check_eq("disp_12", display, 12);
    press(4'd10);
    press(4'd3);
    press(4'd14);
    check_eq("d_req", bus.alu_req_o, 1);
    check_eq("d_a", bus.alu_a_o, 12);
    check_eq("d_b", bus.alu_b_o, 3);
    check_eq("d_op", bus.alu_op_o, 0);
    repeat (2) @(negedge clk);
    bus.alu_ack_i = 1'b1;
    bus.alu_result_i = 16'd15;
    @(negedge clk);
    bus.alu_ack_i = 1'b0;
    check_eq("d_we", bus.we_o, 1);
    check_eq("d_waddr", bus.waddr_o, 0);
    check_eq("d_wdata", bus.wdata_o, 15);
    @(negedge clk);
    check_eq("d_count", count, 1);
    check_eq("d_state", state, 0);
    exp_mem[0] = 15;
    exp_wptr = 1;
    exp_nops = 1;

    // Digit limit.
    repeat (4) press(4'd9);
    check_eq("disp_9999", display, 9999);
    press(4'd9);
    check_eq("fifth_err", error, 1);
    check_eq("fifth_disp", display, 9999);
    @(negedge clk);
    check_eq("fifth_single", error, 0);
    press(4'd15);
    check_eq("clr_disp", display, 0);
    check_eq("clr_err", error, 0);

    // Errors in GET_A with no digits.
    press(4'd11);
    check_eq("op_nodig_err", error, 1);
    check_eq("op_nodig_state", state, 0);
    @(negedge clk);
    check_eq("op_nodig_single", error, 0);
    press(4'd14);
    check_eq("e_in_a_err", error, 1);
    check_eq("e_in_a_state", state, 0);

    run_op(1'b0, 1'b1);
    run_op(1'b0, 1'b0);
    sweep_check(14);

    for (int i = 0; i < 9; i++) run_op((i == 3) || ($urandom_range(7) == 0), 1'b0);
    sweep_check(3 * SC * DEPTH / 2);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    mode = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_raddr", bus.raddr_o, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_disp", display, 0);
    check_eq("mid_rst_waddr", bus.waddr_o, 0);
    check_eq("mid_rst_wdata", bus.wdata_o, 0);
    @(negedge clk);
    mode = 1'b0;
    rst_n = 1'b1;
    model_reset();
    run_op(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
